dm_subword_unit: RTL and testbench
==================================

Name: dm_subword_unit

Overview:
- Data-memory access unit between the CPU datapath and a word-wide synchronous RAM.
- On stores it narrows 32-bit register data into byte or halfword lanes. On loads it extracts those lanes and zero- or sign-extends them back to 32 bits.
- It is the memory-side counterpart of the immediate extender: it both packs sub-word data and re-widens it.
- Sub-word stores use an internal read-modify-write sequence. Loads have one cycle of read latency.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the internal RAM; must be a power of two.
- IDX_W, 10, word-index width; must equal log2(DEPTH_WORDS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  access request; accepted when req && ready
- we  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; the used bits are always wdata[7:0], [15:0] or [31:0]
- ready  out  1  unit can accept a request this cycle
- rvalid  out  1  one-cycle pulse; rdata is valid
- rdata  out  32  extended load result
- misalign  out  1  one-cycle pulse; the accepted request was rejected

Behaviour:
- Lane mapping is little-endian: byte k occupies RAM word bits [8k+7:8k], with k = addr[1:0].
- Halfword lane is addr[1]: 0 selects [15:0], 1 selects [31:16].
- Word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Rejection: a request is rejected if size == 11, if a halfword has addr[0] = 1, or if a word has addr[1:0] != 00.
  - A rejected request causes no RAM access.
  - misalign = 1 in the cycle after acceptance; rvalid stays 0.
  - The FSM stays in IDLE.
- FSM states: IDLE, LOAD_WAIT, RMW_RD, RMW_WR.
  - IDLE: ready = 1.
  - IDLE, accepted word store: RAM write at that clock edge; stay in IDLE (no stall).
  - IDLE, accepted load: issue RAM read and latch lane/size/sign_ext; go to LOAD_WAIT.
  - IDLE, accepted byte/half store: issue RAM read of the target word and latch addr, size and wdata; go to RMW_RD.
  - LOAD_WAIT: ready = 0. rdata = extended lane of the RAM output, rvalid = 1 for exactly this cycle, then go to IDLE.
  - RMW_RD: ready = 0. Merge the latched wdata lane into the RAM output word and write it back at the clock edge; go to RMW_WR.
  - RMW_WR: ready = 0. One settling cycle, then go to IDLE.
  - Throughput: one load per 2 cycles, one sub-word store per 3 cycles, one word store per cycle.
- Extension rules:
  - Byte: sign_ext ? {{24{b[7]}}, b} : {24'b0, b}.
  - Half: the same rule on bit 15.
  - Word: sign_ext is ignored.
- rdata holds its last value when rvalid = 0.
- req while ready = 0 is ignored; the requester must hold req until accepted.
- Reset (reset = 0, asynchronous):
  - FSM returns to IDLE; ready = 0 while reset is asserted, 1 from the first clock after release.
  - rvalid = 0, misalign = 0, rdata = 32'h0.
  - RAM contents are not cleared.
  - Reset asserted during RMW_RD: the merged write is suppressed and the RAM word is unchanged.
  - Reset asserted during LOAD_WAIT: no rvalid pulse.
- rvalid and misalign are never high in the same cycle.

Test Plan:
- Word store 0x8000_00F0 to addr 0x10, then byte load addr 0x10 with sign_ext = 1 -> rvalid one cycle after accept, rdata = 0xFFFF_FFF0; repeat with sign_ext = 0 -> 0x0000_00F0.
- Word store 0x1122_3344 to 0x20, byte store 0xAB to 0x22 -> ready low for 2 cycles; word load 0x20 -> 0x11AB_3344.
- Halfword store 0x8001 to 0x26, half load 0x26 with sign_ext = 1 -> 0xFFFF_8001; half load 0x24 -> lower half unchanged.
- Half load at 0x31, word store at 0x32, size = 11 -> each pulses misalign one cycle after accept, no rvalid, RAM at 0x30 unchanged, ready stays 1.
- With DEPTH_WORDS = 1024: word store to 0x1000 aliases 0x0000 -> word load 0x0 returns the stored value.
- Assert reset during RMW_RD of byte store 0xFF to 0x20 (word 0x1122_3344) -> after release ready = 1, rvalid = 0, word load 0x20 = 0x1122_3344.

Source files
------------

// File: rtl/dm_subword_unit.sv
// Data-memory access unit: narrows stores into byte/half lanes of a word RAM
// (read-modify-write for sub-word) and re-widens loads with zero/sign extension.
module dm_subword_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        misalign
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_RD, RMW_WR} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       off;
        logic [1:0]       size;
        logic             sext;
        logic [15:0]      wdata;
    } lat_t;

    state_t           state;
    lat_t             lat;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      ram_q;
    logic [31:0]      rdata_q;
    logic [31:0]      ld_ext;
    logic [31:0]      ram_wd;
    logic [IDX_W-1:0] ram_widx;
    logic [IDX_W-1:0] idx;
    logic             accept, bad, ok, wr_word, rd_issue, ram_we;

    // Upper address bits only alias; they are intentionally dropped.
    wire unused_addr = &{1'b0, addr[31:IDX_W+2], 1'b0};

    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [1:0] off,
                                               input logic [1:0] sz, input logic [15:0] d);
        logic [31:0] m;
        m = old;
        if (sz == SZ_B) m[8*off +: 8] = d[7:0];
        else            m[16*off[1] +: 16] = d;
        return m;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        case (sz)
            SZ_B:    r = sx ? {{24{b[7]}}, b} : {24'b0, b};
            SZ_H:    r = sx ? {{16{h[15]}}, h} : {16'b0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign idx      = addr[IDX_W+1:2];
    assign accept   = req && ready;
    assign bad      = (size == 2'b11) || (size == SZ_H && addr[0]) ||
                      (size == SZ_W && addr[1:0] != 2'b00);
    assign ok       = accept && !bad;
    assign wr_word  = ok && we && (size == SZ_W);
    assign rd_issue = ok && !(we && (size == SZ_W));

    // Gating with reset keeps an in-flight merge from landing while reset is asserted.
    assign ram_we   = wr_word || (state == RMW_RD && reset);
    assign ram_widx = (state == RMW_RD) ? lat.idx : idx;
    assign ram_wd   = (state == RMW_RD) ? merge_lane(ram_q, lat.off, lat.size, lat.wdata) : wdata;

    always_ff @(posedge clk) begin
        if (ram_we)   mem[ram_widx] <= ram_wd;
        if (rd_issue) ram_q <= mem[idx];
    end

    assign ld_ext = extract(ram_q, lat.off, lat.size, lat.sext);
    assign rvalid = (state == LOAD_WAIT);
    assign rdata  = rvalid ? ld_ext : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ready    <= 1'b0;
            misalign <= 1'b0;
            rdata_q  <= 32'h0;
            lat      <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    ready    <= 1'b1;
                    misalign <= accept && bad;
                    if (rd_issue) begin
                        lat   <= '{idx: idx, off: addr[1:0], size: size, sext: sign_ext,
                                   wdata: wdata[15:0]};
                        state <= we ? RMW_RD : LOAD_WAIT;
                        ready <= 1'b0;
                    end
                end
                LOAD_WAIT: begin
                    rdata_q <= ld_ext;
                    state   <= IDLE;
                    ready   <= 1'b1;
                end
                RMW_RD: begin
                    state <= RMW_WR;
                    ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_subword_unit.sv
// Directed self-checking bench for dm_subword_unit.
module tb_dm_subword_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, rvalid, misalign;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    dm_subword_unit #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Drives one request, waits (bounded) for acceptance; returns at accept edge + 1.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr=%h ready=%b required 1", a, ready);
        end
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                        output logic rv, output logic [31:0] rd);
        issue(1'b0, sz, sx, a, 32'h0);
        @(negedge clk);
        rv = rvalid;
        rd = rdata;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
    endtask

    task automatic test_byte_load_ext;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_00F0);
        load(2'b00, 1'b1, 32'h10, rv, rd);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL lb_sext_rvalid got=%b exp=1", rv); end
        checks++; if (rd !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_sext got=%h exp=FFFFFFF0", rd); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lb_ready_wait got=%b exp=0", ready); end
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL lb_rvalid_pulse got=%b exp=0", rvalid); end
        checks++; if (rdata !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_rdata_hold got=%h exp=FFFFFFF0", rdata); end
        load(2'b00, 1'b0, 32'h10, rv, rd);
        checks++; if (rd !== 32'h0000_00F0) begin errors++; $display("FAIL lb_zext got=%h exp=000000F0", rd); end
        load(2'b00, 1'b1, 32'h13, rv, rd);
        checks++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_top_sext got=%h exp=FFFFFF80", rd); end
    endtask

    task automatic test_byte_store;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAB);
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sb_ready_c1 got=%b exp=0", ready); end
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sb_ready_c2 got=%b exp=0", ready); end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sb_ready_c3 got=%b exp=1", ready); end
        load(2'b10, 1'b0, 32'h20, rv, rd);
        checks++; if (rd !== 32'h11AB_3344) begin errors++; $display("FAIL sb_word got=%h exp=11AB3344", rd); end
        load(2'b00, 1'b1, 32'h22, rv, rd);
        checks++; if (rd !== 32'hFFFF_FFAB) begin errors++; $display("FAIL sb_lb got=%h exp=FFFFFFAB", rd); end
        load(2'b00, 1'b0, 32'h23, rv, rd);
        checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL sb_lb3 got=%h exp=00000011", rd); end
    endtask

    task automatic test_half;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h24, 32'h5566_7788);
        issue(1'b1, 2'b01, 1'b0, 32'h26, 32'h0000_8001);
        load(2'b01, 1'b1, 32'h26, rv, rd);
        checks++; if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_sext got=%h exp=FFFF8001", rd); end
        load(2'b01, 1'b0, 32'h26, rv, rd);
        checks++; if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lh_zext got=%h exp=00008001", rd); end
        load(2'b01, 1'b1, 32'h24, rv, rd);
        checks++; if (rd !== 32'h0000_7788) begin errors++; $display("FAIL lh_low got=%h exp=00007788", rd); end
        issue(1'b1, 2'b01, 1'b0, 32'h24, 32'h1234_BEEF);
        load(2'b10, 1'b1, 32'h24, rv, rd);
        checks++; if (rd !== 32'h8001_BEEF) begin errors++; $display("FAIL sh_word got=%h exp=8001BEEF", rd); end
    endtask

    task automatic test_misalign;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D);
        issue(1'b0, 2'b01, 1'b1, 32'h31, 32'h0);
        @(negedge clk);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_lh got=%b exp=1", misalign); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL mis_lh_rvalid got=%b exp=0", rvalid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mis_lh_ready got=%b exp=1", ready); end
        @(negedge clk);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", misalign); end
        issue(1'b1, 2'b10, 1'b0, 32'h32, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_sw got=%b exp=1", misalign); end
        issue(1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        checks++; if (misalign !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL mis_size11 got=%b/%b exp=1/0", misalign, rvalid); end
        issue(1'b1, 2'b01, 1'b0, 32'h33, 32'h0000_5555);
        @(negedge clk);
        checks++; if (misalign !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL mis_sh got=%b/%b exp=1/1", misalign, ready); end
        load(2'b10, 1'b0, 32'h30, rv, rd);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_ram got=%h exp=CAFEF00D", rd); end
    endtask

    task automatic test_alias;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1357_9BDF);
        load(2'b10, 1'b0, 32'h0, rv, rd);
        checks++; if (rd !== 32'h1357_9BDF) begin errors++; $display("FAIL alias got=%h exp=13579BDF", rd); end
    endtask

    task automatic test_back_to_back;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5_0001);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", ready); end
        issue(1'b1, 2'b10, 1'b0, 32'h44, 32'h5A5A_0002);
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000_0077);
        load(2'b10, 1'b0, 32'h40, rv, rd);
        checks++; if (rd !== 32'hA5A5_7701) begin errors++; $display("FAIL b2b_w0 got=%h exp=A5A57701", rd); end
        load(2'b10, 1'b0, 32'h44, rv, rd);
        checks++; if (rd !== 32'h5A5A_0002) begin errors++; $display("FAIL b2b_w1 got=%h exp=5A5A0002", rd); end
    endtask

    task automatic test_reset_mid_op;
        logic rv; logic [31:0] rd;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_00FF);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_rmw_during got=%b/%b exp=0/0", ready, rvalid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_rmw_after got=%b/%b exp=1/0", ready, rvalid); end
        load(2'b10, 1'b0, 32'h20, rv, rd);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL rst_rmw_ram got=%h exp=11223344", rd); end
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        reset = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_load_rvalid got=%b exp=0", rvalid); end
        @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_load_rdata got=%h exp=0", rdata); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_byte_load_ext;
        test_byte_store;
        test_half;
        test_misalign;
        test_alias;
        test_back_to_back;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
